// File: rtl/load_store_unit_if.sv
// Bus bundles for load_store_unit.
//   load_store_unit_req_if : execute stage (master) <-> LSU (slave) request/response
//   load_store_unit_mem_if : LSU (master) <-> data memory (slave) read/write ports
interface load_store_unit_req_if;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] RespData;
    logic        RespErr;

    modport master (
        output ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RespReady,
        input  ReqReady, RespValid, RespData, RespErr
    );
    modport slave (
        input  ReqValid, ReqWrite, ReqSize, ReqSigned, ReqAddr, ReqWData, RespReady,
        output ReqReady, RespValid, RespData, RespErr
    );
endinterface

interface load_store_unit_mem_if;
    logic        ReadValid;
    logic [31:0] ReadAddr;
    logic [31:0] ReadData;
    logic        ReadReady;
    logic        WriteValid;
    logic [31:0] WriteAddr;
    logic [31:0] WriteData;

    modport master (
        output ReadValid, ReadAddr, WriteValid, WriteAddr, WriteData,
        input  ReadData, ReadReady
    );
    modport slave (
        input  ReadValid, ReadAddr, WriteValid, WriteAddr, WriteData,
        output ReadData, ReadReady
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: one-at-a-time load/store engine between execute stage and
// a word-wide data memory. Loads read a word and extract/extend the lane;
// sub-word stores do read-modify-write; misaligned or illegal sizes answer
// with RespErr and no memory traffic.
// Build option: define LSU_SUBWORD_EN to support byte/halfword accesses;
// without it only word accesses are legal and all others return an error.
module load_store_unit (
    input  logic                  CLK,
    input  logic                  RSTn,
    load_store_unit_req_if.slave  req,
    load_store_unit_mem_if.master mem
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] WRITE = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0]  state;
    logic [31:2] word_addr_q;   // word address of the request
    logic [31:0] wdata_q;       // store data, later the full word to write
    logic [31:0] resp_data_q;
    logic        resp_err_q;
    logic        req_err;

`ifdef LSU_SUBWORD_EN
    logic [1:0]  lane_q;        // byte offset inside the word
    logic [1:0]  size_q;
    logic        signed_q;
    logic        write_q;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_value;
    logic [31:0] merged_word;

    // Misalignment / illegal-size detection with sub-word support
    always_comb begin
        case (req.ReqSize)
            2'd0:    req_err = 1'b0;
            2'd1:    req_err = req.ReqAddr[0];
            2'd2:    req_err = |req.ReqAddr[1:0];
            default: req_err = 1'b1;
        endcase
    end

    // Lane extraction with extension for loads, lane merge for sub-word stores
    always_comb begin
        // NOTE: every variable gets a default before the case so no path infers a latch.
        byte_lane   = mem.ReadData[{lane_q, 3'b000} +: 8];
        half_lane   = lane_q[1] ? mem.ReadData[31:16] : mem.ReadData[15:0];
        load_value  = mem.ReadData;
        merged_word = mem.ReadData;
        case (size_q)
            2'd0: begin
                load_value = {{24{signed_q & byte_lane[7]}}, byte_lane};
                merged_word[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            end
            2'd1: begin
                load_value = {{16{signed_q & half_lane[15]}}, half_lane};
                if (lane_q[1]) merged_word[31:16] = wdata_q[15:0];
                else           merged_word[15:0]  = wdata_q[15:0];
            end
            default: ;
        endcase
    end
`else
    // Word-only build: anything but an aligned word is an error
    assign req_err = (req.ReqSize != 2'd2) || (|req.ReqAddr[1:0]);
`endif

    // Request capture, state sequencing and response registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state       <= IDLE;
            word_addr_q <= '0;
            wdata_q     <= '0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
`ifdef LSU_SUBWORD_EN
            lane_q      <= '0;
            size_q      <= '0;
            signed_q    <= 1'b0;
            write_q     <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking so every register here sees pre-edge values.
            case (state)
                IDLE: begin
                    if (req.ReqValid) begin
                        word_addr_q <= req.ReqAddr[31:2];
                        wdata_q     <= req.ReqWData;
                        resp_data_q <= '0;
                        resp_err_q  <= req_err;
`ifdef LSU_SUBWORD_EN
                        lane_q      <= req.ReqAddr[1:0];
                        size_q      <= req.ReqSize;
                        signed_q    <= req.ReqSigned;
                        write_q     <= req.ReqWrite;
                        if (req_err)                  state <= RESP;
                        else if (!req.ReqWrite)       state <= READ;
                        else if (req.ReqSize == 2'd2) state <= WRITE;
                        else                          state <= READ;
`else
                        if (req_err)            state <= RESP;
                        else if (!req.ReqWrite) state <= READ;
                        else                    state <= WRITE;
`endif
                    end
                end
                READ: begin
                    if (mem.ReadReady) begin
`ifdef LSU_SUBWORD_EN
                        if (write_q) begin
                            wdata_q <= merged_word;
                            state   <= WRITE;
                        end else begin
                            resp_data_q <= load_value;
                            state       <= RESP;
                        end
`else
                        resp_data_q <= mem.ReadData;
                        state       <= RESP;
`endif
                    end
                end
                WRITE: state <= RESP;
                default: begin
                    if (req.RespReady) state <= IDLE;
                end
            endcase
        end
    end

    // Outputs decode straight from state; addresses/data are zero when not valid
    assign req.ReqReady   = (state == IDLE);
    assign req.RespValid  = (state == RESP);
    assign req.RespData   = req.RespValid ? resp_data_q : 32'h0;
    assign req.RespErr    = req.RespValid & resp_err_q;
    assign mem.ReadValid  = (state == READ);
    assign mem.ReadAddr   = mem.ReadValid ? {word_addr_q, 2'b00} : 32'h0;
    assign mem.WriteValid = (state == WRITE);
    assign mem.WriteAddr  = mem.WriteValid ? {word_addr_q, 2'b00} : 32'h0;
    assign mem.WriteData  = mem.WriteValid ? wdata_q : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed vector table, multi-cycle corner
// sequences (memory wait states, response back-pressure, reset during a
// write) and randomized requests against a byte-array reference model.
module tb_load_store_unit;

`ifdef LSU_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    always #5 CLK = ~CLK;

    load_store_unit_req_if req_bus ();
    load_store_unit_mem_if mem_bus ();

    load_store_unit dut (
        .CLK  (CLK),
        .RSTn (RSTn),
        .req  (req_bus),
        .mem  (mem_bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- memory environment ----------------
    logic [31:0] mem [64];
    logic [7:0]  ref_bytes [256];
    int          stall_left = 0;
    int          read_cycles = 0;
    int          write_cycles = 0;
    logic        wr_pend = 1'b0;
    logic [31:0] wr_pend_addr = '0;
    logic [31:0] wr_pend_data = '0;
    logic        prev_rvalid = 1'b0;
    logic [31:0] prev_raddr = '0;

    // Capture the write committed at this posedge
    always @(posedge CLK) begin
        wr_pend      <= mem_bus.WriteValid;
        wr_pend_addr <= mem_bus.WriteAddr;
        wr_pend_data <= mem_bus.WriteData;
    end

    // Apply committed writes, answer reads (with wait states), watch the bus
    always @(negedge CLK) begin
        if (wr_pend) mem[wr_pend_addr[7:2]] = wr_pend_data;
        if (mem_bus.ReadValid && stall_left > 0) begin
            mem_bus.ReadReady = 1'b0;
            mem_bus.ReadData  = $urandom;
            stall_left--;
        end else if (mem_bus.ReadValid) begin
            mem_bus.ReadReady = 1'b1;
            mem_bus.ReadData  = mem[mem_bus.ReadAddr[7:2]];
        end else begin
            mem_bus.ReadReady = 1'b0;
            mem_bus.ReadData  = '0;
        end
        if (mem_bus.ReadValid) begin
            read_cycles++;
            check("read_addr_align", {30'h0, mem_bus.ReadAddr[1:0]}, 32'h0);
            if (prev_rvalid) check("read_addr_stable", mem_bus.ReadAddr, prev_raddr);
        end else begin
            check("read_addr_idle", mem_bus.ReadAddr, 32'h0);
        end
        if (mem_bus.WriteValid) begin
            write_cycles++;
        end else begin
            check("write_addr_idle", mem_bus.WriteAddr, 32'h0);
            check("write_data_idle", mem_bus.WriteData, 32'h0);
        end
        prev_rvalid = mem_bus.ReadValid;
        prev_raddr  = mem_bus.ReadAddr;
    end

    task automatic set_word(input int idx, input logic [31:0] w);
        mem[idx] = w;
        for (int b = 0; b < 4; b++) ref_bytes[idx * 4 + b] = w[8 * b +: 8];
    endtask

    task automatic init_memory();
        for (int i = 0; i < 64; i++) set_word(i, $urandom);
    endtask

    function automatic logic [31:0] ref_word(input int idx);
        return {ref_bytes[idx * 4 + 3], ref_bytes[idx * 4 + 2], ref_bytes[idx * 4 + 1], ref_bytes[idx * 4]};
    endfunction

    // ---------------- reference model (byte-array view of memory) ----------------
    task automatic model(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input int stalls,
                         output logic [31:0] exp_data, output logic exp_err, output int exp_lat,
                         output int exp_reads, output int exp_writes);
        int n;
        int base;
        logic [31:0] v;
        n          = 1 << sz;
        exp_err    = (sz == 2'd3) || ((a & (n - 1)) != 0) || (!SUBWORD && sz != 2'd2);
        exp_data   = '0;
        exp_reads  = 0;
        exp_writes = 0;
        exp_lat    = 1;
        if (exp_err) return;
        base = int'(a[7:0]);
        if (!wr) begin
            v = '0;
            for (int i = 0; i < n; i++) v = v | ({24'h0, ref_bytes[base + i]} << (8 * i));
            if (sg && n < 4 && v[8 * n - 1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
            exp_data  = v;
            exp_lat   = 2 + stalls;
            exp_reads = 1 + stalls;
        end else begin
            for (int i = 0; i < n; i++) ref_bytes[base + i] = wd[8 * i +: 8];
            exp_writes = 1;
            if (n == 4) begin
                exp_lat = 2;
            end else begin
                exp_lat   = 3 + stalls;
                exp_reads = 1 + stalls;
            end
        end
    endtask

    // ---------------- request driver ----------------
    task automatic issue(input logic wr, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input int stalls, input int resp_wait,
                         output logic [31:0] data, output logic err, output int lat,
                         output int reads, output int writes);
        int n;
        @(negedge CLK);
        stall_left          = stalls;
        req_bus.ReqValid    = 1'b1;
        req_bus.ReqWrite    = wr;
        req_bus.ReqSize     = sz;
        req_bus.ReqSigned   = sg;
        req_bus.ReqAddr     = a;
        req_bus.ReqWData    = wd;
        n = 0;
        while (!req_bus.ReqReady && n < 20) begin
            @(negedge CLK);
            n++;
        end
        check("req_ready_wait", req_bus.ReqReady, 32'h1);
        read_cycles  = 0;
        write_cycles = 0;
        @(posedge CLK);
        #1 req_bus.ReqValid = 1'b0;
        lat = 0;
        do begin
            @(negedge CLK);
            lat++;
            check("req_ready_busy", req_bus.ReqReady, 32'h0);
        end while (!req_bus.RespValid && lat < 50);
        check("resp_valid_seen", req_bus.RespValid, 32'h1);
        data = req_bus.RespData;
        err  = req_bus.RespErr;
        for (int i = 0; i < resp_wait; i++) begin
            @(negedge CLK);
            check("resp_valid_hold", req_bus.RespValid, 32'h1);
            check("resp_data_hold", req_bus.RespData, data);
            check("resp_err_hold", req_bus.RespErr, err);
            check("req_ready_hold", req_bus.ReqReady, 32'h0);
        end
        req_bus.RespReady = 1'b1;
        @(posedge CLK);
        #1 req_bus.RespReady = 1'b0;
        reads  = read_cycles;
        writes = write_cycles;
        @(negedge CLK);
        check("req_ready_after", req_bus.ReqReady, 32'h1);
        check("resp_valid_after", req_bus.RespValid, 32'h0);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_data;
        logic        exp_err;
        int          exp_lat;
        bit          sub;       // sub-word access: becomes an error in word-only builds
    } vec_t;

    function automatic vec_t mk(input string nm, input logic wr, input logic [1:0] sz, input logic sg,
                                input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] ed,
                                input logic ee, input int el, input bit sub);
        vec_t v;
        v.name = nm; v.wr = wr; v.sz = sz; v.sg = sg; v.addr = addr; v.wd = wd;
        v.exp_data = ed; v.exp_err = ee; v.exp_lat = el; v.sub = sub;
        return v;
    endfunction

    initial begin
        vec_t        vecs[$];
        logic [31:0] d;
        logic        e;
        int          lat, rd, wr_n;
        logic [31:0] exp_d;
        logic        exp_e;
        int          exp_l, exp_r, exp_w;
        int          n;

        req_bus.ReqValid  = 1'b0;
        req_bus.ReqWrite  = 1'b0;
        req_bus.ReqSize   = 2'd0;
        req_bus.ReqSigned = 1'b0;
        req_bus.ReqAddr   = '0;
        req_bus.ReqWData  = '0;
        req_bus.RespReady = 1'b0;
        init_memory();
        set_word(8,  32'h0000_80F0);   // 0x20
        set_word(12, 32'h1122_3344);   // 0x30

        vecs.push_back(mk("st_word_10",   1, 2, 0, 32'h10, 32'hDEAD_BEEF, 32'h0,         0, 2, 0));
        vecs.push_back(mk("ld_word_10",   0, 2, 0, 32'h10, 32'h0,         32'hDEAD_BEEF, 0, 2, 0));
        vecs.push_back(mk("ld_byte_s_20", 0, 0, 1, 32'h20, 32'h0,         32'hFFFF_FFF0, 0, 2, 1));
        vecs.push_back(mk("ld_half_u_20", 0, 1, 0, 32'h20, 32'h0,         32'h0000_80F0, 0, 2, 1));
        vecs.push_back(mk("ld_half_s_22", 0, 1, 1, 32'h22, 32'h0,         32'h0000_0000, 0, 2, 1));
        vecs.push_back(mk("ld_half_s_20", 0, 1, 1, 32'h20, 32'h0,         32'hFFFF_80F0, 0, 2, 1));
        vecs.push_back(mk("ld_byte_u_21", 0, 0, 0, 32'h21, 32'h0,         32'h0000_0080, 0, 2, 1));
        vecs.push_back(mk("st_byte_33",   1, 0, 0, 32'h33, 32'h1234_56AB, 32'h0,         0, 3, 1));
        vecs.push_back(mk("ld_word_30",   0, 2, 0, 32'h30, 32'h0,
                          SUBWORD ? 32'hAB22_3344 : 32'h1122_3344,         0, 2, 0));
        vecs.push_back(mk("st_half_32",   1, 1, 0, 32'h32, 32'hFFFF_5A5A, 32'h0,         0, 3, 1));
        vecs.push_back(mk("ld_word_30b",  0, 2, 0, 32'h30, 32'h0,
                          SUBWORD ? 32'h5A5A_3344 : 32'h1122_3344,         0, 2, 0));
        vecs.push_back(mk("ld_word_06",   0, 2, 0, 32'h06, 32'h0,         32'h0,         1, 1, 0));
        vecs.push_back(mk("ld_half_05",   0, 1, 0, 32'h05, 32'h0,         32'h0,         1, 1, 0));
        vecs.push_back(mk("ld_size3_00",  0, 3, 0, 32'h00, 32'h0,         32'h0,         1, 1, 0));
        vecs.push_back(mk("st_word_12",   1, 2, 0, 32'h12, 32'hFFFF_FFFF, 32'h0,         1, 1, 0));

        // Reset state
        #12;
        check("rst_req_ready", req_bus.ReqReady, 32'h1);
        check("rst_resp_valid", req_bus.RespValid, 32'h0);
        check("rst_read_valid", mem_bus.ReadValid, 32'h0);
        check("rst_write_valid", mem_bus.WriteValid, 32'h0);
        @(negedge CLK);
        RSTn = 1'b1;
        @(negedge CLK);
        check("init_req_ready", req_bus.ReqReady, 32'h1);
        check("init_resp_data", req_bus.RespData, 32'h0);
        check("init_resp_err", req_bus.RespErr, 32'h0);

        // Directed table
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            if (!SUBWORD && v.sub) begin
                v.exp_data = '0;
                v.exp_err  = 1'b1;
                v.exp_lat  = 1;
            end
            issue(v.wr, v.sz, v.sg, v.addr, v.wd, 0, 0, d, e, lat, rd, wr_n);
            check({v.name, "_data"}, d, v.exp_data);
            check({v.name, "_err"}, e, v.exp_err);
            check({v.name, "_lat"}, lat, v.exp_lat);
            check({v.name, "_reads"}, rd, (!v.exp_err && (!v.wr || v.sz != 2'd2)) ? 1 : 0);
            check({v.name, "_writes"}, wr_n, (!v.exp_err && v.wr) ? 1 : 0);
        end

        // Memory wait states plus response back-pressure on a word load
        set_word(16, 32'hCAFE_F00D);
        issue(0, 2, 0, 32'h40, 32'h0, 3, 2, d, e, lat, rd, wr_n);
        check("stall_data", d, 32'hCAFE_F00D);
        check("stall_err", e, 32'h0);
        check("stall_lat", lat, 32'd5);
        check("stall_reads", rd, 32'd4);

        // Reset asserted while the write strobe is up
        set_word(20, 32'h1122_3344);
        @(negedge CLK);
        req_bus.ReqValid  = 1'b1;
        req_bus.ReqWrite  = 1'b1;
        req_bus.ReqSize   = SUBWORD ? 2'd0 : 2'd2;
        req_bus.ReqSigned = 1'b0;
        req_bus.ReqAddr   = SUBWORD ? 32'h53 : 32'h50;
        req_bus.ReqWData  = 32'hEEEE_EEEE;
        @(posedge CLK);
        #1 req_bus.ReqValid = 1'b0;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!mem_bus.WriteValid && n < 20);
        check("rst_mid_write_seen", mem_bus.WriteValid, 32'h1);
        RSTn = 1'b0;
        #1;
        check("rst_mid_write_drop", mem_bus.WriteValid, 32'h0);
        check("rst_mid_write_data", mem_bus.WriteData, 32'h0);
        check("rst_mid_req_ready", req_bus.ReqReady, 32'h1);
        @(negedge CLK);
        RSTn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            check("rst_mid_no_resp", req_bus.RespValid, 32'h0);
            check("rst_mid_ready", req_bus.ReqReady, 32'h1);
        end
        check("rst_mid_mem", mem[20], 32'h1122_3344);

        // Randomized requests against the reference model
        init_memory();
        for (int it = 0; it < 300; it++) begin
            logic        r_wr, r_sg;
            logic [1:0]  r_sz;
            logic [31:0] r_a, r_wd, hi;
            logic [7:0]  lo;
            int          r_st, r_rw;
            r_wr = 1'($urandom_range(0, 1));
            r_sz = 2'($urandom_range(0, 3));
            r_sg = 1'($urandom_range(0, 1));
            hi   = $urandom;
            lo   = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0 && r_sz != 2'd3) lo = lo & ~((8'h1 << r_sz) - 8'h1);
            r_a  = {hi[31:8], lo};
            r_wd = $urandom;
            r_st = $urandom_range(0, 2);
            r_rw = $urandom_range(0, 2);
            model(r_wr, r_sz, r_sg, r_a, r_wd, r_st, exp_d, exp_e, exp_l, exp_r, exp_w);
            issue(r_wr, r_sz, r_sg, r_a, r_wd, r_st, r_rw, d, e, lat, rd, wr_n);
            check("rnd_data", d, exp_d);
            check("rnd_err", e, exp_e);
            check("rnd_lat", lat, exp_l);
            check("rnd_reads", rd, exp_r);
            check("rnd_writes", wr_n, exp_w);
            check("rnd_word", mem[r_a[7:2]], ref_word(int'(r_a[7:2])));
        end
        for (int i = 0; i < 64; i++) check("final_mem", mem[i], ref_word(i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
